// File: rtl/cpu_pkg.sv
// Shared definitions for the integer pipeline: default widths, MIPS-subset
// opcode/funct encodings, ALU operation codes and the ID/EX control bundle.
package cpu_pkg;

   localparam int DATA_WIDTH_DEF     = 32;
   localparam int REG_ADDR_WIDTH_DEF = 5;

   // Opcodes, instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct, instr[5:0]
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_e;

   // Control carried through ID/EX; all-zero is a bubble / NOP.
   typedef struct packed {
      alu_op_e alu_op;
      logic    alu_src_imm;
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    branch;
      logic    jump;
      logic    illegal;
   } id_ex_ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational opcode/funct decode into the ID/EX control bundle.
// Ports:
//   opcode, funct : instruction fields [31:26] and [5:0]
//   ctrl          : decoded controls (illegal=1, everything else 0, if unknown)
//   dest_rd       : destination is rd (R-type) rather than rt
//   uses_rt       : instruction reads rt as a source (for load-use detection)
module instr_decoder
   import cpu_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   output id_ex_ctrl_t ctrl,
   output logic        dest_rd,
   output logic        uses_rt
);

   always_comb begin
      ctrl    = '0;
      dest_rd = 1'b0;
      uses_rt = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            dest_rd        = 1'b1;
            uses_rt        = 1'b1;
            ctrl.reg_write = 1'b1;
            case (funct)
               FN_ADD:  ctrl.alu_op = ALU_ADD;
               FN_SUB:  ctrl.alu_op = ALU_SUB;
               FN_AND:  ctrl.alu_op = ALU_AND;
               FN_OR:   ctrl.alu_op = ALU_OR;
               FN_SLT:  ctrl.alu_op = ALU_SLT;
               default: begin
                  ctrl.reg_write = 1'b0;
                  ctrl.illegal   = 1'b1;
               end
            endcase
         end
         OP_ADDI: begin
            ctrl.alu_src_imm = 1'b1;
            ctrl.reg_write   = 1'b1;
         end
         OP_LW: begin
            ctrl.alu_src_imm = 1'b1;
            ctrl.mem_read    = 1'b1;
            ctrl.reg_write   = 1'b1;
         end
         OP_SW: begin
            uses_rt          = 1'b1;
            ctrl.alu_src_imm = 1'b1;
            ctrl.mem_write   = 1'b1;
         end
         OP_BEQ: begin
            uses_rt      = 1'b1;
            ctrl.alu_op  = ALU_SUB;
            ctrl.branch  = 1'b1;
         end
         OP_J:    ctrl.jump    = 1'b1;
         default: ctrl.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: drives RegisterFile read addresses, decodes the
// IF/ID instruction, merges a writeback bypass into the operands, detects
// load-use hazards and registers everything into ID/EX.
// Ports:
//   clk, resetN                  : clock, async active-low reset
//   idValid, idInstr, idReady    : IF/ID handshake (idReady=0 -> IF/ID holds)
//   readRegister1/2, readData1/2 : RegisterFile read ports
//   wbRegWrite, wbDestReg, wbData: writeback port (bypass source)
//   exFlush                      : taken branch/jump in EX, kills ID
//   ex*                          : ID/EX register contents
module decode_stage
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      idValid,
   input  logic [31:0]               idInstr,
   output logic                      idReady,
   output logic [REG_ADDR_WIDTH-1:0] readRegister1,
   output logic [REG_ADDR_WIDTH-1:0] readRegister2,
   input  logic [DATA_WIDTH-1:0]     readData1,
   input  logic [DATA_WIDTH-1:0]     readData2,
   input  logic                      wbRegWrite,
   input  logic [REG_ADDR_WIDTH-1:0] wbDestReg,
   input  logic [DATA_WIDTH-1:0]     wbData,
   input  logic                      exFlush,
   output logic                      exValid,
   output logic [DATA_WIDTH-1:0]     exRsData,
   output logic [DATA_WIDTH-1:0]     exRtData,
   output logic [DATA_WIDTH-1:0]     exImm,
   output logic [REG_ADDR_WIDTH-1:0] exDestReg,
   output logic [2:0]                exAluOp,
   output logic                      exAluSrcImm,
   output logic                      exRegWrite,
   output logic                      exMemRead,
   output logic                      exMemWrite,
   output logic                      exBranch,
   output logic                      exJump,
   output logic [25:0]               exJumpTarget,
   output logic                      exIllegal
);

   logic [REG_ADDR_WIDTH-1:0] rs, rt, rd, dest;
   logic [DATA_WIDTH-1:0]     op_a, op_b, imm;
   id_ex_ctrl_t               dec_ctrl, ctrl, ex_ctrl;
   logic                      dest_rd, uses_rt, load_use, issue;

   assign rs = idInstr[21 +: REG_ADDR_WIDTH];
   assign rt = idInstr[16 +: REG_ADDR_WIDTH];
   assign rd = idInstr[11 +: REG_ADDR_WIDTH];

   assign readRegister1 = rs;
   assign readRegister2 = rt;

   instr_decoder u_dec (
      .opcode  (idInstr[31:26]),
      .funct   (idInstr[5:0]),
      .ctrl    (dec_ctrl),
      .dest_rd (dest_rd),
      .uses_rt (uses_rt)
   );

   assign dest = dest_rd ? rd : rt;

   // Writes to r0 are architecturally discarded, so drop the enable here.
   always_comb begin
      ctrl = dec_ctrl;
      if (dest == '0) ctrl.reg_write = 1'b0;
   end

   // RegisterFile updates at the edge, so a same-cycle write must be bypassed.
   // r0 reads as zero regardless of what the file or writeback presents.
   function automatic logic [DATA_WIDTH-1:0] bypass(
      input logic [REG_ADDR_WIDTH-1:0] idx,
      input logic [DATA_WIDTH-1:0]     rf
   );
      if (idx == '0)                            return '0;
      else if (wbRegWrite && wbDestReg == idx)  return wbData;
      else                                      return rf;
   endfunction

   assign op_a = bypass(rs, readData1);
   assign op_b = bypass(rt, readData2);
   assign imm  = {{(DATA_WIDTH-16){idInstr[15]}}, idInstr[15:0]};

   // The loaded value only exists after MEM, so a dependent instruction waits
   // one cycle; the bubble clears exMemRead, so the stall never exceeds one.
   assign load_use = idValid && exValid && exMemRead && exDestReg != '0 &&
                     (exDestReg == rs || (uses_rt && exDestReg == rt));

   assign idReady = !load_use || exFlush;
   assign issue   = idValid && !load_use && !exFlush;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN || !issue) begin
         exValid      <= 1'b0;
         ex_ctrl      <= '0;
         exRsData     <= '0;
         exRtData     <= '0;
         exImm        <= '0;
         exDestReg    <= '0;
         exJumpTarget <= '0;
      end else begin
         exValid      <= 1'b1;
         ex_ctrl      <= ctrl;
         exRsData     <= op_a;
         exRtData     <= op_b;
         exImm        <= imm;
         exDestReg    <= dest;
         exJumpTarget <= idInstr[25:0];
      end
   end

   assign exAluOp     = ex_ctrl.alu_op;
   assign exAluSrcImm = ex_ctrl.alu_src_imm;
   assign exRegWrite  = ex_ctrl.reg_write;
   assign exMemRead   = ex_ctrl.mem_read;
   assign exMemWrite  = ex_ctrl.mem_write;
   assign exBranch    = ex_ctrl.branch;
   assign exJump      = ex_ctrl.jump;
   assign exIllegal   = ex_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan steps followed by randomized
// traffic, all checked against an instruction-level reference model.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        resetN;
   logic        idValid;
   logic [31:0] idInstr;
   logic        idReady;
   logic [4:0]  readRegister1, readRegister2;
   logic [31:0] readData1, readData2;
   logic        wbRegWrite;
   logic [4:0]  wbDestReg;
   logic [31:0] wbData;
   logic        exFlush;
   logic        exValid;
   logic [31:0] exRsData, exRtData, exImm;
   logic [4:0]  exDestReg;
   logic [2:0]  exAluOp;
   logic        exAluSrcImm, exRegWrite, exMemRead, exMemWrite;
   logic        exBranch, exJump, exIllegal;
   logic [25:0] exJumpTarget;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .resetN(resetN), .idValid(idValid), .idInstr(idInstr),
      .idReady(idReady), .readRegister1(readRegister1), .readRegister2(readRegister2),
      .readData1(readData1), .readData2(readData2), .wbRegWrite(wbRegWrite),
      .wbDestReg(wbDestReg), .wbData(wbData), .exFlush(exFlush), .exValid(exValid),
      .exRsData(exRsData), .exRtData(exRtData), .exImm(exImm), .exDestReg(exDestReg),
      .exAluOp(exAluOp), .exAluSrcImm(exAluSrcImm), .exRegWrite(exRegWrite),
      .exMemRead(exMemRead), .exMemWrite(exMemWrite), .exBranch(exBranch),
      .exJump(exJump), .exJumpTarget(exJumpTarget), .exIllegal(exIllegal)
   );

   // Expected ID/EX contents
   typedef struct packed {
      logic        v;
      logic [4:0]  dst;
      logic [2:0]  op;
      logic        src, rw, mr, mw, br, j, ill;
      logic [25:0] jt;
      logic [31:0] a, b, imm;
   } exp_t;

   exp_t m;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
      if (idx == 0) return 32'd0;
      if (wbRegWrite && wbDestReg == idx) return wbData;
      return rf;
   endfunction

   // What the instruction in ID should turn into, given the model's view of EX.
   function automatic void model(output exp_t nx, output logic rdy);
      logic [5:0] opc, fn;
      logic [4:0] rs, rt, rd;
      logic       urt, lu;
      opc = idInstr[31:26]; fn = idInstr[5:0];
      rs = idInstr[25:21]; rt = idInstr[20:16]; rd = idInstr[15:11];
      nx = '0;
      urt = 1'b0;
      nx.dst = (opc == 6'h00) ? rd : rt;
      case (opc)
         6'h00: begin
            urt = 1'b1; nx.rw = 1'b1;
            case (fn)
               6'h20: nx.op = 3'd0;
               6'h22: nx.op = 3'd1;
               6'h24: nx.op = 3'd2;
               6'h25: nx.op = 3'd3;
               6'h2A: nx.op = 3'd4;
               default: begin nx.rw = 1'b0; nx.ill = 1'b1; end
            endcase
         end
         6'h08: begin nx.src = 1'b1; nx.rw = 1'b1; end
         6'h23: begin nx.src = 1'b1; nx.rw = 1'b1; nx.mr = 1'b1; end
         6'h2B: begin nx.src = 1'b1; nx.mw = 1'b1; urt = 1'b1; end
         6'h04: begin nx.op = 3'd1; nx.br = 1'b1; urt = 1'b1; end
         6'h02: nx.j = 1'b1;
         default: nx.ill = 1'b1;
      endcase
      if (nx.dst == 0) nx.rw = 1'b0;
      lu = idValid && m.v && m.mr && m.dst != 0 && (m.dst == rs || (urt && m.dst == rt));
      rdy = !lu || exFlush;
      if (exFlush || lu || !idValid) begin
         nx = '0;
      end else begin
         nx.v   = 1'b1;
         nx.a   = operand(rs, readData1);
         nx.b   = operand(rt, readData2);
         nx.imm = {{16{idInstr[15]}}, idInstr[15:0]};
         nx.jt  = idInstr[25:0];
      end
   endfunction

   task automatic check_out(input string tag);
      chk({tag, ".ctl"},
          {exValid, exDestReg, exAluOp, exAluSrcImm, exRegWrite, exMemRead,
           exMemWrite, exBranch, exJump, exIllegal, exJumpTarget},
          {m.v, m.dst, m.op, m.src, m.rw, m.mr, m.mw, m.br, m.j, m.ill, m.jt});
      chk({tag, ".data"}, {exRsData, exRtData, exImm}, {m.a, m.b, m.imm});
   endtask

   logic last_rdy = 1'b1;

   // One clock: check combinational outputs, take the edge, check ID/EX.
   task automatic step(input string tag);
      exp_t nx;
      logic rdy;
      #1;
      model(nx, rdy);
      chk({tag, ".rdy"}, idReady, rdy);
      chk({tag, ".raddr"}, {readRegister1, readRegister2}, idInstr[25:16]);
      @(posedge clk);
      #1;
      m = nx;
      last_rdy = rdy;
      check_out(tag);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] opcs [10];
      logic [5:0] fns  [5];
      logic [5:0] opc, fn;
      opcs = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
      fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      opc  = opcs[$urandom_range(0, 9)];
      if ($urandom_range(0, 15) == 0) opc = 6'($urandom);
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      if (opc == 6'h00)
         return {opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom), fn};
      if (opc == 6'h02)
         return {opc, 26'($urandom)};
      return {opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
   endfunction

   task automatic rand_steps(input int n);
      for (int i = 0; i < n; i++) begin
         if (last_rdy) idInstr = rand_instr();
         idValid    = ($urandom_range(0, 7) != 0);
         exFlush    = ($urandom_range(0, 9) == 0);
         readData1  = $urandom;
         readData2  = $urandom;
         wbRegWrite = $urandom_range(0, 1);
         wbDestReg  = 5'($urandom_range(0, 3));
         wbData     = $urandom;
         step("rand");
      end
   endtask

   initial begin
      m = '0;
      resetN = 1'b0; idValid = 1'b1; idInstr = 32'h00221820;
      readData1 = 32'd5; readData2 = 32'd7;
      wbRegWrite = 1'b0; wbDestReg = 5'd0; wbData = 32'd0; exFlush = 1'b0;
      #2;
      check_out("reset");
      @(posedge clk); #1;
      check_out("reset_edge");
      @(negedge clk);
      resetN = 1'b1;

      // ADD r3,r1,r2
      step("add");
      chk("add_rs", exRsData, 32'd5);
      chk("add_rt", exRtData, 32'd7);
      chk("add_dst", {exValid, exDestReg, exAluOp, exRegWrite}, {1'b1, 5'd3, 3'd0, 1'b1});

      // ADDI r4,r0,-1 : r0 reads zero whatever the file returns
      idInstr = 32'h2004FFFF; readData1 = 32'hDEAD;
      step("addi");
      chk("addi_imm", exImm, 32'hFFFFFFFF);
      chk("addi_rs", exRsData, 32'd0);
      chk("addi_src", exAluSrcImm, 1'b1);

      // LW r5,0(r1) then ADD r6,r5,r5 : exactly one stall
      idInstr = 32'h8C250000;
      step("lw");
      idInstr = 32'h00A53020;
      #1 chk("lu_ready", idReady, 1'b0);
      step("lu_bubble");
      chk("lu_bubble_v", exValid, 1'b0);
      step("lu_issue");
      chk("lu_issue_v", {exValid, exDestReg}, {1'b1, 5'd6});

      // Bypass from writeback
      idInstr = 32'h00221820; readData1 = 32'd0;
      wbRegWrite = 1'b1; wbDestReg = 5'd1; wbData = 32'hFF;
      step("byp_hit");
      chk("byp_hit_rs", exRsData, 32'hFF);
      wbDestReg = 5'd0; readData1 = 32'h11;
      step("byp_miss");
      chk("byp_miss_rs", exRsData, 32'h11);
      wbRegWrite = 1'b0;

      // Flush concurrent with a load-use hazard
      idInstr = 32'h8C250000;
      step("lw2");
      idInstr = 32'h00A53020; exFlush = 1'b1;
      #1 chk("flush_ready", idReady, 1'b1);
      step("flush");
      chk("flush_v", exValid, 1'b0);
      exFlush = 1'b0;

      // Unknown opcode
      idInstr = 32'hFC000000;
      step("illegal");
      chk("illegal_ctl", {exValid, exIllegal, exRegWrite, exMemRead, exMemWrite},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

      rand_steps(300);

      // Asynchronous reset in the middle of traffic
      @(negedge clk);
      resetN = 1'b0;
      #1;
      m = '0;
      last_rdy = 1'b1;
      check_out("async_reset");
      @(negedge clk);
      resetN = 1'b1;

      rand_steps(300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
